// File: rtl/axi4_read_master.sv
// AXI4-Lite single-read initiator, one transaction in flight, watchdog abort on a silent responder.
// Latency: rsp_valid two cycles after acceptance at best; req_ready low until the result strobe retires, rsp has no backpressure.
module axi4_read_master #(
    parameter int          ADDRESS_WIDTH  = 2,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     axi_clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [1:0]               rsp_resp,
    output logic                     rsp_timeout,
    output logic [ADDRESS_WIDTH-1:0] read_addr,
    output logic                     read_addr_valid,
    input  logic                     read_addr_ready,
    input  logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     read_data_valid,
    output logic                     read_data_ready,
    input  logic [1:0]               read_resp,
    input  logic                     read_resp_valid,
    output logic                     read_resp_ready
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    localparam int            WD_W     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [WD_W:0] WD_LIMIT = (WD_W + 1)'(TIMEOUT_CYCLES);

    state_t                   state, state_nxt;
    logic [WD_W-1:0]          wd_cnt, wd_nxt;
    logic [WD_W:0]            wd_inc;
    logic                     expire;
    logic                     data_got, data_got_nxt, resp_got, resp_got_nxt;
    logic [DATA_WIDTH-1:0]    data_buf, data_buf_nxt;
    logic [1:0]               resp_buf, resp_buf_nxt;
    logic                     data_hs, resp_hs, both_done;
    logic [ADDRESS_WIDTH-1:0] read_addr_nxt;
    logic                     read_addr_valid_nxt, read_data_ready_nxt, read_resp_ready_nxt;
    logic                     req_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt;
    logic [DATA_WIDTH-1:0]    rsp_data_nxt;
    logic [1:0]               rsp_resp_nxt;

    // wd_cnt holds the edges already spent; the abort fires on the TIMEOUT_CYCLES-th edge.
    assign wd_inc    = {1'b0, wd_cnt} + {{WD_W{1'b0}}, 1'b1};
    assign expire    = (TIMEOUT_CYCLES != 0) && (wd_inc == WD_LIMIT);
    assign data_hs   = read_data_valid & read_data_ready;
    assign resp_hs   = read_resp_valid & read_resp_ready;
    assign both_done = (data_got | data_hs) & (resp_got | resp_hs);

    always_comb begin
        state_nxt           = state;
        wd_nxt              = wd_cnt;
        data_got_nxt        = data_got;
        resp_got_nxt        = resp_got;
        data_buf_nxt        = data_buf;
        resp_buf_nxt        = resp_buf;
        read_addr_nxt       = read_addr;
        read_addr_valid_nxt = read_addr_valid;
        read_data_ready_nxt = read_data_ready;
        read_resp_ready_nxt = read_resp_ready;
        req_ready_nxt       = req_ready;
        rsp_valid_nxt       = 1'b0;
        rsp_data_nxt        = rsp_data;
        rsp_resp_nxt        = rsp_resp;
        rsp_timeout_nxt     = rsp_timeout;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    read_addr_nxt       = req_addr;
                    read_addr_valid_nxt = 1'b1;
                    data_got_nxt        = 1'b0;
                    resp_got_nxt        = 1'b0;
                    wd_nxt              = '0;
                    req_ready_nxt       = 1'b0;
                    state_nxt           = ADDR;
                end
            end
            ADDR: begin
                wd_nxt = wd_inc[WD_W-1:0];
                if (read_addr_ready) begin
                    read_addr_valid_nxt = 1'b0;
                    read_data_ready_nxt = 1'b1;
                    read_resp_ready_nxt = 1'b1;
                    state_nxt           = WAIT;
                end else if (expire) begin
                    read_addr_valid_nxt = 1'b0;
                    rsp_valid_nxt       = 1'b1;
                    rsp_timeout_nxt     = 1'b1;
                    rsp_data_nxt        = '0;
                    rsp_resp_nxt        = 2'b10;
                    state_nxt           = DONE;
                end
            end
            WAIT: begin
                wd_nxt = wd_inc[WD_W-1:0];
                if (data_hs) begin
                    data_buf_nxt        = read_data;
                    data_got_nxt        = 1'b1;
                    read_data_ready_nxt = 1'b0;
                end
                if (resp_hs) begin
                    resp_buf_nxt        = read_resp;
                    resp_got_nxt        = 1'b1;
                    read_resp_ready_nxt = 1'b0;
                end
                // A completion landing on the expiry edge is reported as a normal result.
                if (both_done) begin
                    read_data_ready_nxt = 1'b0;
                    read_resp_ready_nxt = 1'b0;
                    rsp_valid_nxt       = 1'b1;
                    rsp_timeout_nxt     = 1'b0;
                    rsp_data_nxt        = data_hs ? read_data : data_buf;
                    rsp_resp_nxt        = resp_hs ? read_resp : resp_buf;
                    state_nxt           = DONE;
                end else if (expire) begin
                    read_data_ready_nxt = 1'b0;
                    read_resp_ready_nxt = 1'b0;
                    rsp_valid_nxt       = 1'b1;
                    rsp_timeout_nxt     = 1'b1;
                    rsp_data_nxt        = '0;
                    rsp_resp_nxt        = 2'b10;
                    state_nxt           = DONE;
                end
            end
            DONE: begin
                req_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                req_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!resetn) begin
            state           <= IDLE;
            wd_cnt          <= '0;
            data_got        <= 1'b0;
            resp_got        <= 1'b0;
            data_buf        <= '0;
            resp_buf        <= '0;
            read_addr       <= '0;
            read_addr_valid <= 1'b0;
            read_data_ready <= 1'b0;
            read_resp_ready <= 1'b0;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_resp        <= '0;
            rsp_timeout     <= 1'b0;
        end else begin
            state           <= state_nxt;
            wd_cnt          <= wd_nxt;
            data_got        <= data_got_nxt;
            resp_got        <= resp_got_nxt;
            data_buf        <= data_buf_nxt;
            resp_buf        <= resp_buf_nxt;
            read_addr       <= read_addr_nxt;
            read_addr_valid <= read_addr_valid_nxt;
            read_data_ready <= read_data_ready_nxt;
            read_resp_ready <= read_resp_ready_nxt;
            req_ready       <= req_ready_nxt;
            rsp_valid       <= rsp_valid_nxt;
            rsp_data        <= rsp_data_nxt;
            rsp_resp        <= rsp_resp_nxt;
            rsp_timeout     <= rsp_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_axi4_read_master.sv
// Directed bench for axi4_read_master: vector table of responder timings plus back-to-back and reset sequences.
module tb_axi4_read_master;

    logic        axi_clk;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [1:0]  read_addr;
    logic        read_addr_valid;
    logic        read_addr_ready;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        read_data_ready;
    logic [1:0]  read_resp;
    logic        read_resp_valid;
    logic        read_resp_ready;

    axi4_read_master #(
        .ADDRESS_WIDTH (2),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .axi_clk        (axi_clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_resp       (rsp_resp),
        .rsp_timeout    (rsp_timeout),
        .read_addr      (read_addr),
        .read_addr_valid(read_addr_valid),
        .read_addr_ready(read_addr_ready),
        .read_data      (read_data),
        .read_data_valid(read_data_valid),
        .read_data_ready(read_data_ready),
        .read_resp      (read_resp),
        .read_resp_valid(read_resp_valid),
        .read_resp_ready(read_resp_ready)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [1:0]  addr;
        int          ar_dly;
        int          d_dly;
        int          r_dly;
        logic [31:0] data;
        logic [1:0]  resp;
        int          exp_lat;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_tmo;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] mem [4];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_req_ready"},   64'(req_ready),       64'd1);
        chk({tag, "_rsp_valid"},   64'(rsp_valid),       64'd0);
        chk({tag, "_rsp_data"},    64'(rsp_data),        64'd0);
        chk({tag, "_rsp_resp"},    64'(rsp_resp),        64'd0);
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout),     64'd0);
        chk({tag, "_read_addr"},   64'(read_addr),       64'd0);
        chk({tag, "_arvalid"},     64'(read_addr_valid), 64'd0);
        chk({tag, "_rready"},      64'(read_data_ready), 64'd0);
        chk({tag, "_respready"},   64'(read_resp_ready), 64'd0);
    endtask

    task automatic bus_idle();
        read_addr_ready = 1'b0;
        read_data_valid = 1'b0;
        read_resp_valid = 1'b0;
        read_data       = '0;
        read_resp       = '0;
    endtask

    // Issues one request and plays a responder whose channel delays are counted in edges
    // after acceptance (AR) or after the AR handshake (data, resp). Protocol breaches are tallied in viol.
    task automatic run_txn(input logic [1:0] addr, input int ar_dly, input int d_dly, input int r_dly,
                           input logic [31:0] data, input logic [1:0] resp,
                           output int lat, output logic [31:0] got_data, output logic [1:0] got_resp,
                           output logic got_tmo, output int rsp_cnt, output int viol);
        bit ar_done, d_done, r_done, ar_hs, d_hs, r_hs;
        int ar_edge, last;
        lat = -1; got_data = '0; got_resp = '0; got_tmo = 1'b0; rsp_cnt = 0; viol = 0;
        ar_done = 0; d_done = 0; r_done = 0; ar_edge = 0; last = 60;
        bus_idle();
        @(negedge axi_clk);
        if (!req_ready) viol++;
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge axi_clk);
        req_valid = 1'b0;
        for (int n = 1; n <= last; n++) begin
            if (rsp_valid) begin
                rsp_cnt++;
                if (lat < 0) begin
                    lat      = n - 1;
                    got_data = rsp_data;
                    got_resp = rsp_resp;
                    got_tmo  = rsp_timeout;
                    last     = n + 1;
                end
            end
            if (rsp_cnt == 0) begin
                if (req_ready) viol++;
                if (!ar_done && (!read_addr_valid || read_addr !== addr ||
                                 read_data_ready || read_resp_ready)) viol++;
                if (ar_done && read_addr_valid) viol++;
                if (ar_done && (read_data_ready !== !d_done)) viol++;
                if (ar_done && (read_resp_ready !== !r_done)) viol++;
                read_addr_ready = !ar_done && (n >= 1 + ar_dly);
                read_data_valid = ar_done && !d_done && (n >= ar_edge + 1 + d_dly);
                read_resp_valid = ar_done && !r_done && (n >= ar_edge + 1 + r_dly);
                read_data       = data;
                read_resp       = resp;
            end else begin
                bus_idle();
            end
            ar_hs = read_addr_ready && read_addr_valid;
            d_hs  = read_data_valid && read_data_ready;
            r_hs  = read_resp_valid && read_resp_ready;
            @(negedge axi_clk);
            if (ar_hs) begin
                ar_done = 1;
                ar_edge = n;
            end
            if (d_hs) d_done = 1;
            if (r_hs) r_done = 1;
        end
        bus_idle();
    endtask

    initial begin
        int          lat, rsp_cnt, viol, acc, got, last_rsp, seen;
        logic [31:0] gd;
        logic [1:0]  gr;
        logic        gt;

        mem[0] = 32'h11110000;
        mem[1] = 32'hDEADBEEF;
        mem[2] = 32'h12345678;
        mem[3] = 32'h89ABCDEF;

        //          addr   ar  d  r  data           resp   lat exp_data       exp_resp tmo
        vecs[0] = '{2'd1,  0,  0, 0, 32'hDEADBEEF, 2'b00, 2,  32'hDEADBEEF, 2'b00,  1'b0};
        vecs[1] = '{2'd3,  5,  0, 0, 32'hA5A50003, 2'b00, 7,  32'hA5A50003, 2'b00,  1'b0};
        vecs[2] = '{2'd2,  0,  3, 0, 32'h12345678, 2'b10, 5,  32'h12345678, 2'b10,  1'b0};
        vecs[3] = '{2'd0,  1,  0, 2, 32'hCAFEF00D, 2'b11, 5,  32'hCAFEF00D, 2'b11,  1'b0};
        vecs[4] = '{2'd2,  99, 0, 0, 32'h55555555, 2'b00, 8,  32'h00000000, 2'b10,  1'b1};
        vecs[5] = '{2'd2,  0,  0, 0, 32'h0BADC0DE, 2'b00, 2,  32'h0BADC0DE, 2'b00,  1'b0};
        vecs[6] = '{2'd1,  6,  0, 0, 32'h600DF00D, 2'b00, 8,  32'h600DF00D, 2'b00,  1'b0};
        vecs[7] = '{2'd1,  6,  1, 0, 32'h77777777, 2'b00, 8,  32'h00000000, 2'b10,  1'b1};

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        bus_idle();
        repeat (3) @(negedge axi_clk);
        chk_rst("reset");
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].addr, vecs[i].ar_dly, vecs[i].d_dly, vecs[i].r_dly,
                    vecs[i].data, vecs[i].resp, lat, gd, gr, gt, rsp_cnt, viol);
            chk($sformatf("v%0d_latency", i), 64'(lat),     64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_data", i),    64'(gd),      64'(vecs[i].exp_data));
            chk($sformatf("v%0d_resp", i),    64'(gr),      64'(vecs[i].exp_resp));
            chk($sformatf("v%0d_timeout", i), 64'(gt),      64'(vecs[i].exp_tmo));
            chk($sformatf("v%0d_strobes", i), 64'(rsp_cnt), 64'd1);
            chk($sformatf("v%0d_protocol", i), 64'(viol),   64'd0);
        end

        // Back-to-back reads with req_valid held high and a zero-wait responder.
        @(negedge axi_clk);
        acc = 0; got = 0; last_rsp = -1;
        read_addr_ready = 1'b1;
        read_resp       = 2'b00;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            if (cyc > 0) @(negedge axi_clk);
            if (rsp_valid) begin
                chk($sformatf("b2b%0d_data", got), 64'(rsp_data), 64'(mem[got]));
                chk($sformatf("b2b%0d_resp", got), 64'(rsp_resp), 64'd0);
                if (got > 0) chk($sformatf("b2b%0d_gap", got), 64'(cyc - last_rsp), 64'd4);
                last_rsp = cyc;
                got++;
            end
            if (req_ready) begin
                if (acc < 4) begin
                    req_valid = 1'b1;
                    req_addr  = 2'(acc);
                    acc++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            read_data_valid = read_data_ready;
            read_resp_valid = read_resp_ready;
            read_data       = mem[read_addr];
        end
        req_valid = 1'b0;
        bus_idle();
        chk("b2b_count", 64'(got), 64'd4);

        // Reset asserted while waiting for data/response.
        repeat (2) @(negedge axi_clk);
        req_valid = 1'b1;
        req_addr  = 2'd1;
        @(negedge axi_clk);
        req_valid       = 1'b0;
        read_addr_ready = 1'b1;
        @(negedge axi_clk);
        read_addr_ready = 1'b0;
        chk("wait_rready", 64'(read_data_ready), 64'd1);
        resetn = 1'b0;
        @(negedge axi_clk);
        chk_rst("rst_wait");
        resetn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge axi_clk);
            if (rsp_valid) seen++;
        end
        chk("rst_no_rsp", 64'(seen), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
